// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
// The latency helper gives the start-accept to done distance in clk cycles.
package spi_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  function automatic int xfer_latency(input int clk_div, input int data_w);
    return 1 + clk_div * (1 + 2 * data_w);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: counts CLK_DIV cycles while enabled and flags the last one.
// Cleared whenever the FSM changes state so every phase starts from zero.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: shifts tx_data out MSB-first on MOSI while capturing MISO.
// Handshake: start is accepted only in IDLE (busy=0); done pulses once with rx_data valid.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO,
  output spi_state_e        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  spi_state_e state_q, state_d;

  logic              tick;
  logic              div_en;
  logic              div_clr;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_d;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;
  logic              sclk_d, cs_d, mosi_d, busy_d, done_d;

  assign div_en     = (state_q != IDLE);
  assign div_clr    = (state_d != state_q);
  assign tx_shifted = tx_sr_q << 1;
  assign rx_shifted = (rx_sr_q << 1) | DATA_W'(MISO);
  assign dbg_state  = state_q;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (div_en),
    .clr     (div_clr),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The trailing LOW phase after the last fall keeps CS low for one more half period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick)  state_d = HIGH;
      HIGH:    if (tick)  state_d = LOW;
      LOW:     if (tick)  state_d = (bit_cnt_q == LAST_BIT) ? GAP : HIGH;
      GAP:     if (tick)  state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    sclk_d    = SCLK;
    cs_d      = CS;
    mosi_d    = MOSI;
    busy_d    = busy;
    done_d    = 1'b0;
    rx_data_d = rx_data;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          cs_d      = 1'b0;
          mosi_d    = tx_data[DATA_W-1];
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = rx_shifted;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_sr_d   = tx_shifted;
          mosi_d    = tx_shifted[DATA_W-1];
        end
      end
      LOW: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            cs_d      = 1'b1;
            mosi_d    = 1'b0;
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            rx_sr_d = rx_shifted;
          end
        end
      end
      GAP: begin
        if (tick) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      SCLK      <= 1'b0;
      CS        <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      SCLK      <= sclk_d;
      CS        <= cs_d;
      MOSI      <= mosi_d;
      busy      <= busy_d;
      done      <= done_d;
      rx_data   <= rx_data_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with a behavioural mode-0 slave and transfer model.
// A second instance with CLK_DIV=1 covers back-to-back transfers.
module tb_spi_master;
  import spi_pkg::*;

  localparam int DW    = DEF_DATA_W;
  localparam int DIV   = 2;
  localparam int DIV_F = 1;
  localparam int LAT   = xfer_latency(DIV, DW);
  localparam int LAT_F = xfer_latency(DIV_F, DW);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          busy, done, sclk, cs, mosi, miso;
  spi_state_e    dbg_state;

  logic          start_f = 1'b0;
  logic [DW-1:0] tx_data_f = '0;
  logic [DW-1:0] rx_data_f;
  logic          busy_f, done_f, sclk_f, cs_f, mosi_f;
  spi_state_e    dbg_state_f;

  spi_master #(.DATA_W(DW), .CLK_DIV(DIV)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .SCLK(sclk), .CS(cs),
    .MOSI(mosi), .MISO(miso), .dbg_state(dbg_state)
  );

  spi_master #(.DATA_W(DW), .CLK_DIV(DIV_F)) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .start(start_f), .tx_data(tx_data_f),
    .rx_data(rx_data_f), .busy(busy_f), .done(done_f), .SCLK(sclk_f), .CS(cs_f),
    .MOSI(mosi_f), .MISO(mosi_f), .dbg_state(dbg_state_f)
  );

  // behavioural slave and pin monitor for the main instance
  logic          loopback = 1'b0;
  logic [DW-1:0] slave_word = '0;
  logic          slave_bit = 1'b0;
  assign miso = loopback ? mosi : slave_bit;

  int          clr_req = 0;
  int          clr_seen = 0;
  int          rise_cnt = 0, done_cnt = 0, cs_low_len = 0, mosi_viol = 0;
  int unsigned last_done_cyc = 0, busy_fall_cyc = 0;
  logic [DW-1:0] slave_rx = '0;
  logic        sclk_prev = 1'b0, mosi_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rise_cnt = 0; done_cnt = 0; cs_low_len = 0; mosi_viol = 0;
      last_done_cyc = 0; busy_fall_cyc = 0; slave_rx = '0;
    end
    if (sclk && !sclk_prev) begin
      rise_cnt++;
      slave_rx = {slave_rx[DW-2:0], mosi};
      if (mosi !== mosi_prev) mosi_viol++;
    end
    if (!cs) cs_low_len++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    slave_bit = (cs || rise_cnt >= DW) ? 1'b0 : slave_word[DW-1-rise_cnt];
    sclk_prev = sclk;
    mosi_prev = mosi;
    busy_prev = busy;
  end

  // monitor for the fast instance
  logic          b2b_on = 1'b0;
  int unsigned   done_f_cyc[$];
  logic [DW-1:0] rx_f_q[$];
  int            gap_q[$];
  int            cs_f_high = 0;
  logic          cs_f_seen_low = 1'b0;

  always @(negedge clk) begin
    if (b2b_on) begin
      if (done_f) begin
        done_f_cyc.push_back(cyc);
        rx_f_q.push_back(rx_data_f);
      end
      if (cs_f) begin
        cs_f_high++;
      end else begin
        if (cs_f_high > 0 && cs_f_seen_low) gap_q.push_back(cs_f_high);
        cs_f_high = 0;
        cs_f_seen_low = 1'b1;
      end
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One transfer on the main instance; inject pulses start at cycles 5, 20 and the done cycle.
  task automatic run_xfer(input string tag, input logic [DW-1:0] word, input logic lb,
                          input logic [DW-1:0] resp, input logic inject);
    int unsigned c0;
    int guard;
    logic [DW-1:0] exp_rx;
    guard = 0;
    while (busy && guard < 100) begin
      tick_n(1);
      guard++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
    loopback = lb;
    slave_word = resp;
    clr_req++;
    start = 1'b1;
    tx_data = word;
    c0 = cyc;
    exp_rx = lb ? word : resp;
    exp_q.push_back(exp_rx);
    tick_n(1);
    start = 1'b0;
    tx_data = DW'($urandom);
    guard = 0;
    while (done_cnt == 0 && guard < LAT + 20) begin
      tick_n(1);
      guard++;
      start = inject && ((cyc - c0) == 5 || (cyc - c0) == 20 || (cyc - c0) == LAT);
      if (start) tx_data = 8'hFF;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    tick_n(40);
    chk({tag, "_done_lat"}, last_done_cyc - c0, LAT);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_cs_low"}, cs_low_len, LAT - 1);
    chk({tag, "_rises"}, rise_cnt, DW);
    chk({tag, "_mosi_word"}, slave_rx, word);
    chk({tag, "_mosi_stable"}, mosi_viol, 0);
    chk({tag, "_busy_fall"}, busy_fall_cyc - last_done_cyc, DIV);
    chk({tag, "_rx"}, rx_data, exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int guard;
    logic [DW-1:0] w, r, held;

    // reset
    reset_n = 1'b0;
    tick_n(3);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs", cs, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_state_fast", dbg_state_f, IDLE);
    reset_n = 1'b1;
    tick_n(2);

    run_xfer("loop_a5", 8'hA5, 1'b1, 8'h00, 1'b0);
    run_xfer("slave_c3", 8'hC3, 1'b0, 8'h3C, 1'b0);
    w = 8'($urandom_range(0, 254));
    run_xfer("ignored_start", w, 1'b0, 8'($urandom), 1'b1);

    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      r = 8'($urandom);
      run_xfer($sformatf("rand%0d", i), w, (i % 3 == 0), r, 1'b0);
    end

    // rx_data holds between transfers
    held = rx_data;
    tick_n(25);
    chk("rx_hold", rx_data, held);

    // reset mid-transfer after the 4th rising SCLK edge
    w = 8'($urandom_range(1, 255));
    loopback = 1'b1;
    clr_req++;
    start = 1'b1;
    tx_data = w;
    tick_n(1);
    start = 1'b0;
    guard = 0;
    while (rise_cnt < 4 && guard < 100) begin
      tick_n(1);
      guard++;
    end
    chk("midrst_reached4", (rise_cnt >= 4), 1'b1);
    reset_n = 1'b0;
    tick_n(1);
    chk("midrst_cs", cs, 1'b1);
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_rx", rx_data, 8'h00);
    tick_n(2);
    reset_n = 1'b1;
    tick_n(10);
    chk("midrst_no_done", done_cnt, 0);

    // back-to-back on the CLK_DIV=1 instance with MOSI looped to MISO
    b2b_on = 1'b1;
    w = 8'($urandom);
    tx_data_f = w;
    start_f = 1'b1;
    c0 = cyc;
    guard = 0;
    while (done_f_cyc.size() < 4 && guard < 300) begin
      tick_n(1);
      guard++;
    end
    start_f = 1'b0;
    tick_n(30);
    chk("b2b_done_count", (done_f_cyc.size() >= 4), 1'b1);
    // next accept lands on the first busy=0 cycle, CLK_DIV after done
    begin
      int unsigned exp_done;
      exp_done = c0 + LAT_F;
      for (int k = 0; k < 4 && k < done_f_cyc.size(); k++) begin
        chk($sformatf("b2b_done_cyc%0d", k), done_f_cyc[k], exp_done);
        chk($sformatf("b2b_rx%0d", k), rx_f_q[k], w);
        exp_done = exp_done + DIV_F + LAT_F;
      end
    end
    chk("b2b_gap_count", (gap_q.size() >= 3), 1'b1);
    for (int k = 0; k < gap_q.size(); k++) begin
      chk($sformatf("b2b_gap%0d", k), (gap_q[k] >= 1), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
